// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg
//   Shared definitions for the ALU execute front end:
//   - OP_*  : 4-bit function codes arriving on the decoded-instruction port
//   - CMD_* : ALU CTL encodings driven to the ALU instance
//   - EXT_* : immediate extension modes
//   - dec_t : result of decoding one function code
package alu_issue_pkg;

  // Function codes as presented on in_op
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_LT   = 4'd2;
  localparam logic [3:0] OP_LE   = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NAND = 4'd7;
  localparam logic [3:0] OP_NOR  = 4'd8;
  localparam logic [3:0] OP_NXOR = 4'd9;

  // ALU control encodings
  localparam logic [3:0] CMD_ADD  = 4'h0;
  localparam logic [3:0] CMD_SUB  = 4'h1;
  localparam logic [3:0] CMD_LT   = 4'h5;
  localparam logic [3:0] CMD_LE   = 4'h7;
  localparam logic [3:0] CMD_AND  = 4'h8;
  localparam logic [3:0] CMD_OR   = 4'h9;
  localparam logic [3:0] CMD_XOR  = 4'hA;
  localparam logic [3:0] CMD_NAND = 4'hC;
  localparam logic [3:0] CMD_NOR  = 4'hD;
  localparam logic [3:0] CMD_NXOR = 4'hE;

  // Immediate extension modes
  localparam logic EXT_ZERO = 1'b0;
  localparam logic EXT_SIGN = 1'b1;

  typedef struct packed {
    logic [3:0] ctl;
    logic       sext;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/alu_issue_op_decode.sv
// alu_issue_op_decode
//   Combinational decode of the 4-bit function code.
//   Ports:
//     op  in   4      function code
//     dec out  dec_t  {ALU ctl, immediate sign-extend, illegal}
//   Codes 10..15 decode to ADD with the illegal flag set so the op can still
//   travel down the pipe and retire with a zero result.
module alu_issue_op_decode
  import alu_issue_pkg::*;
(
  input  logic [3:0] op,
  output dec_t       dec
);

  always_comb begin
    dec.ctl     = CMD_ADD;
    dec.sext    = EXT_SIGN;
    dec.illegal = 1'b0;
    case (op)
      OP_ADD:  dec.ctl = CMD_ADD;
      OP_SUB:  dec.ctl = CMD_SUB;
      OP_LT:   dec.ctl = CMD_LT;
      OP_LE:   dec.ctl = CMD_LE;
      OP_AND:  begin dec.ctl = CMD_AND;  dec.sext = EXT_ZERO; end
      OP_OR:   begin dec.ctl = CMD_OR;   dec.sext = EXT_ZERO; end
      OP_XOR:  begin dec.ctl = CMD_XOR;  dec.sext = EXT_ZERO; end
      OP_NAND: begin dec.ctl = CMD_NAND; dec.sext = EXT_ZERO; end
      OP_NOR:  begin dec.ctl = CMD_NOR;  dec.sext = EXT_ZERO; end
      OP_NXOR: begin dec.ctl = CMD_NXOR; dec.sext = EXT_ZERO; end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// alu_issue
//   Execute-stage front end for an external ALU. Two-stage pipeline:
//     S1 (issue)  : registered ALU A/B/CTL plus destination tag and illegal flag
//     S2 (result) : captured ALU result, tag and illegal flag feeding writeback
//   One op per cycle, back-pressure from writeback ripples to in_ready.
//   Ports:
//     clk, reset_n                 clock, asynchronous active-low reset
//     in_valid/in_ready            instruction handshake
//     in_op, in_imm_sel            function code, operand B select (1 = immediate)
//     in_rs1, in_rs2, in_imm       operands
//     in_rd                        destination tag
//     alu_a, alu_b, alu_ctl        to the ALU (driven from S1)
//     alu_out                      combinational ALU result
//     out_valid/out_ready          result handshake
//     out_result, out_rd           captured result and its tag
//     out_illegal                  op code was 10..15 (result forced to 0)
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int BITS    = 32,
  parameter int CBITS   = 4,
  parameter int IMMBITS = 16,
  parameter int RBITS   = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_op,
  input  logic               in_imm_sel,
  input  logic [BITS-1:0]    in_rs1,
  input  logic [BITS-1:0]    in_rs2,
  input  logic [IMMBITS-1:0] in_imm,
  input  logic [RBITS-1:0]   in_rd,
  output logic [BITS-1:0]    alu_a,
  output logic [BITS-1:0]    alu_b,
  output logic [CBITS-1:0]   alu_ctl,
  input  logic [BITS-1:0]    alu_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BITS-1:0]    out_result,
  output logic [RBITS-1:0]   out_rd,
  output logic               out_illegal
);

  dec_t dec;

  alu_issue_op_decode u_decode (
    .op  (in_op),
    .dec (dec)
  );

  // Immediate extension: low bits copied, upper bits replicate the sign bit
  // only for arithmetic/compare ops.
  logic [BITS-1:0] imm_ext;
  logic [BITS-1:0] op_b;

  assign imm_ext[IMMBITS-1:0] = in_imm;

  genvar gi;
  generate
    for (gi = IMMBITS; gi < BITS; gi++) begin : g_ext
      assign imm_ext[gi] = dec.sext & in_imm[IMMBITS-1];
    end
  endgenerate

  assign op_b = in_imm_sel ? imm_ext : in_rs2;

  // Stage registers
  logic               s1_valid_reg;
  logic [BITS-1:0]    alu_a_reg;
  logic [BITS-1:0]    alu_b_reg;
  logic [CBITS-1:0]   alu_ctl_reg;
  logic [RBITS-1:0]   s1_rd_reg;
  logic               s1_illegal_reg;

  logic               s2_valid_reg;
  logic [BITS-1:0]    out_result_reg;
  logic [RBITS-1:0]   out_rd_reg;
  logic               out_illegal_reg;

  // A stage advances when it is empty or its downstream advances.
  logic adv1;
  logic adv2;

  assign adv2     = ~s2_valid_reg | out_ready;
  assign adv1     = ~s1_valid_reg | adv2;
  assign in_ready = adv1;

  // S1: issue stage. Data fields only load with a real op; a bubble just
  // clears the valid bit and leaves stale data behind.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_reg   <= 1'b0;
      alu_a_reg      <= '0;
      alu_b_reg      <= '0;
      alu_ctl_reg    <= '0;
      s1_rd_reg      <= '0;
      s1_illegal_reg <= 1'b0;
    end else if (adv1) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        alu_a_reg      <= in_rs1;
        alu_b_reg      <= op_b;
        alu_ctl_reg    <= CBITS'(dec.ctl);
        s1_rd_reg      <= in_rd;
        s1_illegal_reg <= dec.illegal;
      end
    end
  end

  // S2: result stage. Illegal ops retire with a zero result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid_reg    <= 1'b0;
      out_result_reg  <= '0;
      out_rd_reg      <= '0;
      out_illegal_reg <= 1'b0;
    end else if (adv2) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_result_reg  <= s1_illegal_reg ? '0 : alu_out;
        out_rd_reg      <= s1_rd_reg;
        out_illegal_reg <= s1_illegal_reg;
      end
    end
  end

  assign alu_a       = alu_a_reg;
  assign alu_b       = alu_b_reg;
  assign alu_ctl     = alu_ctl_reg;
  assign out_valid   = s2_valid_reg;
  assign out_result  = out_result_reg;
  assign out_rd      = out_rd_reg;
  assign out_illegal = out_illegal_reg;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue
//   Self-checking bench for alu_issue. A stand-in ALU is attached to
//   alu_a/alu_b/alu_ctl. A transaction-level model (a queue of in-flight ops,
//   at most two) predicts in_ready, out_valid, the issue-register contents and
//   every retired result; a negedge compare process checks the DUT each cycle.
//   Directed tests pin the model with hand-computed literals.
module tb_alu_issue;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic        in_imm_sel;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [15:0] in_imm;
  logic [4:0]  in_rd;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctl;
  logic [31:0] alu_out;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_illegal;

  alu_issue dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_imm_sel  (in_imm_sel),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_imm      (in_imm),
    .in_rd       (in_rd),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_ctl     (alu_ctl),
    .alu_out     (alu_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_rd      (out_rd),
    .out_illegal (out_illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in ALU keyed on the CTL encoding
  function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h5: return {31'd0, $signed(a) <  $signed(b)};
      4'h7: return {31'd0, $signed(a) <= $signed(b)};
      4'h8: return a & b;
      4'h9: return a | b;
      4'hA: return a ^ b;
      4'hC: return ~(a & b);
      4'hD: return ~(a | b);
      4'hE: return ~(a ^ b);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_out = alu_fn(alu_ctl, alu_a, alu_b);

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctl;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        ill;
  } ent_t;

  ent_t        q[$];
  int          nvis;          // 1 when q[0] is on the output
  logic [31:0] retired_log[$];

  int total;
  int bad;

  function automatic logic [3:0] exp_ctl(input int op);
    case (op)
      0: return 4'h0;  1: return 4'h1;  2: return 4'h5;  3: return 4'h7;
      4: return 4'h8;  5: return 4'h9;  6: return 4'hA;  7: return 4'hC;
      8: return 4'hD;  9: return 4'hE;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] exp_res(input int op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return ($signed(a) <  $signed(b)) ? 32'd1 : 32'd0;
      3: return ($signed(a) <= $signed(b)) ? 32'd1 : 32'd0;
      4: return a & b;
      5: return a | b;
      6: return a ^ b;
      7: return ~(a & b);
      8: return ~(a | b);
      9: return ~(a ^ b);
      default: return 32'd0;
    endcase
  endfunction

  function automatic ent_t make_ent(input int op, input logic sel, input logic [31:0] r1,
                                    input logic [31:0] r2, input logic [15:0] imm, input logic [4:0] rd);
    ent_t e;
    logic [31:0] immx;
    immx = (op <= 3) ? {{16{imm[15]}}, imm} : {16'h0000, imm};
    e.a   = r1;
    e.b   = sel ? immx : r2;
    e.ctl = exp_ctl(op);
    e.ill = (op > 9);
    e.res = exp_res(op, e.a, e.b);
    e.rd  = rd;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: check against model, then advance model for the coming edge
  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      nvis = 0;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_alu_ctl", {28'd0, alu_ctl}, 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_out_result", out_result, 32'd0);
    end else begin
      logic rdy_exp;
      rdy_exp = !(q.size() == 2 && !out_ready);
      chk("in_ready", {31'd0, in_ready}, {31'd0, rdy_exp});
      chk("out_valid", {31'd0, out_valid}, nvis[31:0]);
      if (nvis == 1) begin
        chk("out_result", out_result, q[0].res);
        chk("out_rd", {27'd0, out_rd}, {27'd0, q[0].rd});
        chk("out_illegal", {31'd0, out_illegal}, {31'd0, q[0].ill});
      end
      if (q.size() > nvis) begin
        chk("alu_a", alu_a, q[nvis].a);
        chk("alu_ctl", {28'd0, alu_ctl}, {28'd0, q[nvis].ctl});
        if (!q[nvis].ill) chk("alu_b", alu_b, q[nvis].b);
      end
      // predict next posedge
      if (nvis == 1 && out_ready) begin
        retired_log.push_back(q[0].res);
        $display("retire rd=%0d res=%h ill=%0d", q[0].rd, q[0].res, q[0].ill);
        void'(q.pop_front());
        nvis = 0;
      end
      if (nvis == 0 && q.size() > 0) nvis = 1;
      if (in_valid && rdy_exp)
        q.push_back(make_ent(int'(in_op), in_imm_sel, in_rs1, in_rs2, in_imm, in_rd));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [3:0] op, input logic sel, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [15:0] imm, input logic [4:0] rd);
    in_valid   = 1'b1;
    in_op      = op;
    in_imm_sel = sel;
    in_rs1     = r1;
    in_rs2     = r2;
    in_imm     = imm;
    in_rd      = rd;
  endtask

  // Present an op and return at posedge+#2 right after it was accepted
  task automatic issue(input logic [3:0] op, input logic sel, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [15:0] imm, input logic [4:0] rd);
    int n;
    @(posedge clk); #2;
    drive(op, sel, r1, r2, imm, rd);
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    if (n == 20) chk("issue_timeout", 32'd0, 32'd1);
    @(posedge clk); #2;
    in_valid = 1'b0;
    $display("issue op=%0d rd=%0d", op, rd);
  endtask

  int base;

  initial begin
    total = 0; bad = 0; nvis = 0;
    reset_n = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; in_op = '0; in_imm_sel = 1'b0;
    in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_rd = '0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;

    // SUB with sign-extended immediate
    issue(4'd1, 1'b1, 32'd5, 32'd0, 16'hFFFF, 5'd3);
    chk("sub_alu_b", alu_b, 32'hFFFF_FFFF);
    chk("sub_alu_ctl", {28'd0, alu_ctl}, 32'h1);
    @(posedge clk); #1;
    chk("sub_out_valid", {31'd0, out_valid}, 32'd1);
    chk("sub_result", out_result, 32'd6);

    // AND with zero-extended immediate
    issue(4'd4, 1'b1, 32'hFFFF_00FF, 32'd0, 16'h8F0F, 5'd4);
    chk("and_alu_b", alu_b, 32'h0000_8F0F);
    @(posedge clk); #1;
    chk("and_result", out_result, 32'h0000_000F);

    // Signed less-than
    issue(4'd2, 1'b0, 32'hFFFF_FFFD, 32'd2, 16'h0, 5'd17);
    chk("lt_alu_ctl", {28'd0, alu_ctl}, 32'h5);
    @(posedge clk); #1;
    chk("lt_result", out_result, 32'd1);
    chk("lt_rd", {27'd0, out_rd}, 32'd17);

    // Illegal op then a legal one
    issue(4'd12, 1'b0, 32'd7, 32'd9, 16'h0, 5'd8);
    @(posedge clk); #1;
    chk("ill_flag", {31'd0, out_illegal}, 32'd1);
    chk("ill_result", out_result, 32'd0);
    issue(4'd0, 1'b0, 32'd1, 32'd2, 16'h0, 5'd9);
    @(posedge clk); #1;
    chk("post_ill_flag", {31'd0, out_illegal}, 32'd0);
    chk("post_ill_result", out_result, 32'd3);

    // Back-pressure: 4 ADDs with writeback stalled for 3 cycles
    repeat (2) @(posedge clk);
    #2;
    base = retired_log.size();
    out_ready = 1'b0;
    drive(4'd0, 1'b0, 32'd0, 32'd0, 16'h0, 5'd20);
    @(posedge clk); #2;
    drive(4'd0, 1'b0, 32'd10, 32'd1, 16'h0, 5'd21);
    @(posedge clk); #2;
    chk("bp_ready_low1", {31'd0, in_ready}, 32'd0);
    drive(4'd0, 1'b0, 32'd20, 32'd2, 16'h0, 5'd22);
    @(posedge clk); #2;
    chk("bp_ready_low2", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #2;
    drive(4'd0, 1'b0, 32'd30, 32'd3, 16'h0, 5'd23);
    @(posedge clk); #2;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("bp_count", retired_log.size() - base, 32'd4);
    if (retired_log.size() - base == 4) begin
      for (int i = 0; i < 4; i++)
        chk("bp_order", retired_log[base + i], 32'(11 * i));
    end

    // Reset mid-stream with both stages valid
    out_ready = 1'b0;
    issue(4'd1, 1'b0, 32'd9, 32'd4, 16'h0, 5'd1);
    issue(4'd1, 1'b0, 32'd8, 32'd4, 16'h0, 5'd2);
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_ctl", {28'd0, alu_ctl}, 32'd0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    out_ready = 1'b1;
    issue(4'd6, 1'b1, 32'h0000_00F0, 32'd0, 16'h00FF, 5'd6);
    @(posedge clk); #1;
    chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("post_rst_result", out_result, 32'h0000_000F);

    // Random traffic checked against the model
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #2;
      in_valid   = ($urandom_range(0, 9) < 7);
      out_ready  = ($urandom_range(0, 3) != 0);
      in_op      = 4'($urandom_range(0, 15));
      in_imm_sel = 1'($urandom);
      in_rs1     = $urandom;
      in_rs2     = ($urandom_range(0, 7) == 0) ? in_rs1 : $urandom;
      case ($urandom_range(0, 3))
        0: in_imm = 16'h8000;
        1: in_imm = 16'hFFFF;
        default: in_imm = 16'($urandom);
      endcase
      in_rd = 5'($urandom);
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    chk("drain_empty", {31'd0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
